// File: rtl/blit_inner_seq_if.sv
// Handshake bundle between the blitter inner-loop sequencer and its neighbours.
// master: outer loop and memory control side; slave: the sequencer itself.
interface blit_inner_seq_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic [CNT_W-1:0] inner_count;
  logic             srcen;
  logic             dsten;
  logic             memready;
  logic             memidle;
  logic             readreq;
  logic             writereq;
  logic             step_inner;
  logic             sread;
  logic             dread;
  logic             dwrite;
  logic             busy;
  logic             done;

  modport master (
    output start, inner_count, srcen, dsten, memready, memidle,
    input  readreq, writereq, step_inner, sread, dread, dwrite, busy, done
  );

  modport slave (
    input  start, inner_count, srcen, dsten, memready, memidle,
    output readreq, writereq, step_inner, sread, dread, dwrite, busy, done
  );
endinterface

// File: rtl/blit_inner_seq.sv
// Blitter inner-loop sequencer: per iteration runs optional source read, optional
// destination read and a destination write through memory control, then pulses done.
module blit_inner_seq #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  blit_inner_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LOAD, REQ, DONE} state_t;

  // op register kept one-hot as {src, dst, wr}; all-zero outside LOAD/REQ
  localparam logic [2:0] OP_SRC = 3'b100;
  localparam logic [2:0] OP_DST = 3'b010;
  localparam logic [2:0] OP_WR  = 3'b001;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             src_en;
  logic             dst_en;
  logic [2:0]       op;
  logic             busy_q;
  logic             done_q;

  function automatic logic [2:0] first_op(input logic s, input logic d);
    if (s)      return OP_SRC;
    else if (d) return OP_DST;
    else        return OP_WR;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      src_en <= 1'b0;
      dst_en <= 1'b0;
      op     <= 3'b000;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            busy_q <= 1'b1;
            if (bus.inner_count != '0) begin
              cnt    <= bus.inner_count;
              src_en <= bus.srcen;
              dst_en <= bus.dsten;
              op     <= first_op(bus.srcen, bus.dsten);
              state  <= LOAD;
            end else begin
              done_q <= 1'b1;
              state  <= DONE;
            end
          end
        end
        LOAD: begin
          if (bus.memidle) state <= REQ;
        end
        REQ: begin
          if (bus.memready) begin
            unique case (op)
              OP_SRC: begin
                op    <= dst_en ? OP_DST : OP_WR;
                state <= LOAD;
              end
              OP_DST: begin
                op    <= OP_WR;
                state <= LOAD;
              end
              default: begin
                cnt <= cnt - 1'b1;
                // terminal test on the pre-decrement value so all-ones never wraps
                if (cnt == CNT_W'(1)) begin
                  op     <= 3'b000;
                  done_q <= 1'b1;
                  state  <= DONE;
                end else begin
                  op    <= first_op(src_en, dst_en);
                  state <= LOAD;
                end
              end
            endcase
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Requests fall combinationally with memready so memory control never re-arms
  assign bus.readreq    = (state == REQ) && (op[2] || op[1]) && !bus.memready;
  assign bus.writereq   = (state == REQ) && op[0] && !bus.memready;
  assign bus.step_inner = (state == LOAD) && bus.memidle;
  assign bus.sread      = op[2];
  assign bus.dread      = op[1];
  assign bus.dwrite     = op[0];
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_blit_inner_seq.sv
// Scoreboard bench for blit_inner_seq with a small memory-control responder.
module tb_blit_inner_seq;
  localparam int CNT_W = 16;

  typedef struct {
    int steps;
    int rd;
    int wr;
    int bsy;
  } stat_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  blit_inner_seq_if #(.CNT_W(CNT_W)) bus ();
  blit_inner_seq #(.CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  int n_tests = 0;
  int n_fail  = 0;

  logic [2:0] exp_op[$];
  stat_t      exp_done[$];

  int rdy_delay = 0, idle_hold = 0, req_age = 0, load_age = 0;
  bit in_req = 0, last_step = 0;
  int c_step = 0, c_rd = 0, c_wr = 0, c_busy = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Memory-control responder: inputs updated just after each rising edge
  always @(posedge clk) begin
    #1;
    if (reset) begin
      bus.memready = 1'b0;
      bus.memidle  = 1'b1;
      load_age     = 0;
    end else begin
      if (bus.memready) in_req = 0;
      if (last_step) begin
        in_req  = 1;
        req_age = 0;
      end
      if (in_req) begin
        bus.memready = (req_age == rdy_delay);
        req_age++;
      end else begin
        bus.memready = 1'b0;
      end
      if ((bus.sread || bus.dread || bus.dwrite) && !in_req) begin
        bus.memidle = (load_age >= idle_hold);
        load_age++;
      end else begin
        bus.memidle = 1'b1;
        load_age    = 0;
      end
    end
  end

  // Monitor: samples at the falling edge and pops the scoreboard
  always @(negedge clk) begin
    stat_t st;
    if (!reset) begin
      if (bus.busy) begin
        c_busy++;
        check("readreq", int'(bus.readreq),
              int'(in_req && (bus.sread || bus.dread) && !bus.memready));
        check("writereq", int'(bus.writereq), int'(in_req && bus.dwrite && !bus.memready));
      end else begin
        check("idle_quiet", int'({bus.readreq, bus.writereq, bus.step_inner}), 0);
      end
      if (bus.readreq)  c_rd++;
      if (bus.writereq) c_wr++;
      if (bus.step_inner) begin
        c_step++;
        if (exp_op.size() == 0) check("step_extra", 1, 0);
        else check("op_order", int'({bus.sread, bus.dread, bus.dwrite}), int'(exp_op.pop_front()));
      end
      last_step = bus.step_inner;
      if (bus.done) begin
        if (exp_done.size() == 0) check("done_extra", 1, 0);
        else begin
          st = exp_done.pop_front();
          check("steps", c_step, st.steps);
          check("rd_cycles", c_rd, st.rd);
          check("wr_cycles", c_wr, st.wr);
          check("busy_cycles", c_busy, st.bsy);
        end
        c_step = 0; c_rd = 0; c_wr = 0; c_busy = 0;
      end
    end
  end

  task automatic clear_model();
    exp_op.delete();
    exp_done.delete();
    in_req = 0; last_step = 0;
    c_step = 0; c_rd = 0; c_wr = 0; c_busy = 0;
  endtask

  task automatic launch(input int n, input bit s, input bit d, input int rdly, input int ihold);
    stat_t st;
    int ops;
    ops = int'(s) + int'(d) + 1;
    for (int i = 0; i < n; i++) begin
      if (s) exp_op.push_back(3'b100);
      if (d) exp_op.push_back(3'b010);
      exp_op.push_back(3'b001);
    end
    st.steps = n * ops;
    st.rd    = n * (int'(s) + int'(d)) * rdly;
    st.wr    = n * rdly;
    st.bsy   = n * ops * ((1 + ihold) + (rdly + 1)) + 1;
    exp_done.push_back(st);
    rdy_delay = rdly;
    idle_hold = ihold;
    @(posedge clk); #1;
    bus.inner_count = CNT_W'(n);
    bus.srcen = s;
    bus.dsten = d;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    // scribble the sampled inputs; the running loop must not notice
    bus.inner_count = '1;
    bus.srcen = !s;
    bus.dsten = !d;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (exp_done.size() != 0 && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    check("timeout", exp_done.size(), 0);
    @(negedge clk);
    check("idle_after", int'(bus.busy), 0);
  endtask

  initial begin
    int k;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.inner_count = '0;
    bus.srcen = 1'b0;
    bus.dsten = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outs", int'({bus.readreq, bus.writereq, bus.step_inner, bus.sread,
                            bus.dread, bus.dwrite, bus.busy, bus.done}), 0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_outs", int'({bus.readreq, bus.writereq, bus.step_inner, bus.sread,
                                 bus.dread, bus.dwrite, bus.busy, bus.done}), 0);

    launch(1, 0, 0, 2, 0);       // single write-only iteration
    wait_done(200);
    launch(3, 1, 1, 1, 0);       // full SRC/DST/WR sequence, 3 iterations
    wait_done(500);
    launch(0, 1, 1, 1, 0);       // zero count
    wait_done(50);
    launch(1, 1, 0, 5, 4);       // memidle and memready back-pressure
    wait_done(500);
    launch(4, 1, 0, 0, 0);       // immediate accept
    wait_done(500);

    // async reset in the middle of a read request
    launch(2, 1, 0, 20, 0);
    k = 0;
    while (!bus.readreq && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("rst_reach_req", int'(bus.readreq), 1);
    #2 reset = 1'b1;
    #1;
    check("rst_readreq", int'(bus.readreq), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_step", int'(bus.step_inner), 0);
    check("rst_sread", int'(bus.sread), 0);
    clear_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    clear_model();
    repeat (6) @(negedge clk);
    check("rst_no_done_busy", int'(bus.busy), 0);
    launch(1, 1, 1, 1, 1);
    wait_done(300);

    // start while busy and while in DONE must be ignored
    launch(2, 0, 1, 1, 0);
    repeat (3) @(posedge clk);
    #1;
    bus.inner_count = CNT_W'(5);
    bus.srcen = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    k = 0;
    while (!bus.done && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("reach_done", int'(bus.done), 1);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    check("ignored_start_busy", int'(bus.busy), 0);
    check("ignored_start_queue", exp_done.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
